// File: rtl/mask_stream_gen.sv
// Thresholds the camera luma stream into masked pixel strobes for the centroid unit,
// then requests a centroid calculation per frame. Define MASK_ROI_EN to also gate masking by the ROI window.
module mask_stream_gen #(
    parameter int H_ACTIVE       = 1280,
    parameter int V_ACTIVE       = 720,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ROI_X0         = 0,
    parameter int ROI_X1         = 1279,
    parameter int ROI_Y0         = 0,
    parameter int ROI_Y1         = 719
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        data_valid,
    input  logic [7:0]  luma,
    input  logic [7:0]  thresh_lo,
    input  logic [7:0]  thresh_hi,
    input  logic        com_valid,
    output logic [10:0] pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic        calculate,
    output logic [19:0] mask_count,
    output logic [15:0] frame_count,
    output logic        timeout_err
);

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [10:0] RX0    = 11'(ROI_X0);
    localparam logic [10:0] RXW    = 11'(ROI_X1 - ROI_X0);
    localparam logic [9:0]  RY0    = 10'(ROI_Y0);
    localparam logic [9:0]  RYW    = 10'(ROI_Y1 - ROI_Y0);
    localparam int          WW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] W_LIMIT = WW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {ARMED, STREAM, FLUSH, CALC, WAIT} state_t;
    state_t state, state_nxt;

    logic          active, at_first, at_last, in_roi, roi_ok;
    logic          take, start, drained;
    logic          s1_vld, s1_start, s1_roi;
    logic [10:0]   s1_x;
    logic [9:0]    s1_y;
    logic [7:0]    s1_luma, s1_lo, s1_hi;
    logic          s2_vld, s2_start, s2_mask;
    logic [10:0]   s2_x;
    logic [9:0]    s2_y;
    logic [19:0]   cnt;
    logic [WW-1:0] wcnt;

    assign active   = data_valid && (hcount < H_ACT) && (vcount < V_ACT);
    assign at_first = active && (hcount == '0) && (vcount == '0);
    assign at_last  = active && (hcount == H_LAST) && (vcount == V_LAST);

    // Offset-and-span compare keeps the window check free of always-true bounds.
    assign in_roi = ((hcount - RX0) <= RXW) && ((vcount - RY0) <= RYW);
`ifdef MASK_ROI_EN
    assign roi_ok = in_roi;
`else
    logic unused_roi;
    assign unused_roi = in_roi;
    assign roi_ok     = 1'b1;
`endif

    assign drained     = !s1_vld && !s2_vld;
    assign calculate   = (state == CALC);
    assign timeout_err = (state == WAIT) && (wcnt == W_LIMIT) && !com_valid;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        start     = 1'b0;
        case (state)
            ARMED: if (at_first) begin
                take      = 1'b1;
                start     = 1'b1;
                state_nxt = at_last ? FLUSH : STREAM;
            end
            STREAM: if (active) begin
                take  = 1'b1;
                start = at_first;
                if (at_last) state_nxt = FLUSH;
            end
            FLUSH:   if (drained) state_nxt = (cnt != '0) ? CALC : ARMED;
            CALC:    state_nxt = WAIT;
            WAIT:    if (com_valid || wcnt == W_LIMIT) state_nxt = ARMED;
            default: state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARMED;
            s1_vld      <= 1'b0;
            s1_start    <= 1'b0;
            s1_roi      <= 1'b0;
            s1_x        <= '0;
            s1_y        <= '0;
            s1_luma     <= '0;
            s1_lo       <= '0;
            s1_hi       <= '0;
            s2_vld      <= 1'b0;
            s2_start    <= 1'b0;
            s2_mask     <= 1'b0;
            s2_x        <= '0;
            s2_y        <= '0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            cnt         <= '0;
            mask_count  <= '0;
            frame_count <= '0;
            wcnt        <= '0;
        end else begin
            state <= state_nxt;

            s1_vld   <= take;
            s1_start <= start;
            if (take) begin
                s1_roi  <= roi_ok;
                s1_x    <= hcount;
                s1_y    <= vcount;
                s1_luma <= luma;
                s1_lo   <= thresh_lo;
                s1_hi   <= thresh_hi;
            end

            s2_vld   <= s1_vld;
            s2_start <= s1_start;
            s2_mask  <= s1_vld && s1_roi && (s1_luma >= s1_lo) && (s1_luma <= s1_hi);
            s2_x     <= s1_x;
            s2_y     <= s1_y;

            pixel_valid <= s2_vld && s2_mask;
            if (s2_vld && s2_mask) begin
                pixel_x <= s2_x;
                pixel_y <= s2_y;
            end

            // A frame-start pixel restarts the count, which also covers short frames.
            if (s2_vld) cnt <= (s2_start ? 20'd0 : cnt) + 20'(s2_mask);

            if (state == FLUSH && drained) mask_count <= cnt;

            wcnt <= (state == WAIT) ? wcnt + WW'(1) : '0;

            if (state == WAIT && com_valid) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mask_stream_gen.sv
// Randomised/directed bench for mask_stream_gen on a small frame geometry; expectations come
// from a frame-level model of which pixels are masked and when results must appear.
module tb_mask_stream_gen;
    localparam int H = 16, V = 8, TO = 80;
    localparam int RX0 = 0, RX1 = 7, RY0 = 0, RY1 = 3;

    logic        clk = 1'b0, rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        data_valid, com_valid;
    logic [7:0]  luma, thresh_lo, thresh_hi;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid, calculate, timeout_err;
    logic [19:0] mask_count;
    logic [15:0] frame_count;

    mask_stream_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT_CYCLES(TO),
        .ROI_X0(RX0), .ROI_X1(RX1), .ROI_Y0(RY0), .ROI_Y1(RY1)
    ) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .data_valid(data_valid),
        .luma(luma), .thresh_lo(thresh_lo), .thresh_hi(thresh_hi), .com_valid(com_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid), .calculate(calculate),
        .mask_count(mask_count), .frame_count(frame_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int x; int y; } px_t;
    px_t        exp_px[$], got_px[$];
    int         got_calc[$], got_to[$];
    int         cyc = 0;
    int         n_cmp = 0, n_bad = 0;
    int         mode, exp_fc, t_last, n, n_full, last_calc;
    logic [7:0] lum [V][H];

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: cycle numbers are posedge counts, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (pixel_valid) begin
                px_t p;
                p.t = cyc; p.x = int'(pixel_x); p.y = int'(pixel_y);
                got_px.push_back(p);
            end
            if (calculate)   got_calc.push_back(cyc);
            if (timeout_err) got_to.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of run, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic bit masked(int x, int y, int l);
        bit m;
        m = (l >= int'(thresh_lo)) && (l <= int'(thresh_hi));
`ifdef MASK_ROI_EN
        m = m && x >= RX0 && x <= RX1 && y >= RY0 && y <= RY1;
`else
        m = m && x < H && y < V;
`endif
        return m;
    endfunction

    function automatic int pix_luma(int x, int y);
        case (mode)
            0:       return ((x == 3 && y == 2) || (x == 10 && y == 5)) ? 100 : 0;
            1:       return int'(lum[y][x]);
            default: return 128;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input bit v, input int l, input bit cv);
        hcount = 11'(x); vcount = 10'(y); data_valid = v; luma = 8'(l); com_valid = cv;
        tick();
    endtask

    task automatic fill_random();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) lum[y][x] = 8'($urandom_range(0, 255));
    endtask

    // Sends rows y0..y1-1. 'live' says whether the block should be accepting this frame.
    task automatic send_frame(input int y0, input int y1, input bit live, input bit cv_first,
                              input bit gaps, output int tl, output int cnt);
        int l;
        cnt = 0; tl = 0;
        for (int y = y0; y < y1; y++) begin
            for (int x = 0; x < H; x++) begin
                if (gaps && $urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 1) == 1)
                        drive(H + int'($urandom_range(0, 3)), y, 1'b1, 128, $urandom_range(0, 7) == 0);
                    else
                        drive(x, y, 1'b0, 128, $urandom_range(0, 7) == 0);
                end
                l = pix_luma(x, y);
                drive(x, y, 1'b1, l, cv_first && x == 0 && y == y0);
                if (live && masked(x, y, l)) begin
                    px_t p;
                    p.t = cyc + 2; p.x = x; p.y = y;
                    exp_px.push_back(p);
                    cnt++;
                end
                tl = cyc;
            end
        end
        data_valid = 1'b0; com_valid = 1'b0;
    endtask

    // cnt < 0 means the frame did not complete, so mask_count is not judged.
    task automatic check_frame(input string tag, input int tl, input bit calc, input int cnt);
        int m;
        repeat (6) tick();
        chk({tag, ".npix"}, got_px.size(), exp_px.size());
        m = (got_px.size() < exp_px.size()) ? got_px.size() : exp_px.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, ".pix_t"}, got_px[i].t, exp_px[i].t);
            chk({tag, ".pix_x"}, got_px[i].x, exp_px[i].x);
            chk({tag, ".pix_y"}, got_px[i].y, exp_px[i].y);
        end
        chk({tag, ".ncalc"}, got_calc.size(), int'(calc));
        if (calc && got_calc.size() > 0) chk({tag, ".calc_t"}, got_calc[0], tl + 3);
        if (cnt >= 0) chk({tag, ".mask_count"}, int'(mask_count), cnt);
        last_calc = tl + 3;
        exp_px.delete(); got_px.delete(); got_calc.delete();
    endtask

    task automatic handshake(input string tag, input int delay);
        while (cyc < last_calc + delay) tick();
        com_valid = 1'b1;
        tick();
        com_valid = 1'b0;
        exp_fc++;
        tick();
        chk({tag, ".frame_count"}, int'(frame_count), exp_fc);
        chk({tag, ".no_timeout"}, got_to.size(), 0);
        got_to.delete();
    endtask

    initial begin
        rst = 1'b1; hcount = '0; vcount = '0; data_valid = 1'b0; luma = '0;
        thresh_lo = 8'd90; thresh_hi = 8'd110; com_valid = 1'b0; exp_fc = 0;
        repeat (3) tick();
        chk("reset.pixel_valid", int'(pixel_valid), 0);
        chk("reset.calculate", int'(calculate), 0);
        chk("reset.mask_count", int'(mask_count), 0);
        chk("reset.frame_count", int'(frame_count), 0);
        chk("reset.timeout_err", int'(timeout_err), 0);
        rst = 1'b0;
        tick();

        // Two in-threshold spots, then acknowledge 50 cycles after calculate.
        mode = 0;
        send_frame(0, V, 1'b1, 1'b0, 1'b0, t_last, n);
        check_frame("spot", t_last, 1'b1, n);
        handshake("spot", 50);

        // Empty frame: inverted thresholds mask nothing and no calculate is issued.
        mode = 1; fill_random();
        thresh_lo = 8'd200; thresh_hi = 8'd50;
        send_frame(0, V, 1'b1, 1'b0, 1'b0, t_last, n);
        check_frame("empty", t_last, 1'b0, 0);

        // Random frame with blanking, out-of-range pixels and stray com_valid pulses.
        fill_random();
        thresh_lo = 8'($urandom_range(0, 127));
        thresh_hi = 8'(int'(thresh_lo) + int'($urandom_range(30, 120)));
        send_frame(0, V, 1'b1, 1'b0, 1'b1, t_last, n);
        check_frame("random", t_last, n != 0, n);
        if (n != 0) handshake("random", int'($urandom_range(5, 60)));

        // Timeout: no acknowledge ever arrives.
        mode = 2; thresh_lo = 8'd0; thresh_hi = 8'd255;
        send_frame(0, V, 1'b1, 1'b0, 1'b0, t_last, n);
        check_frame("tmo", t_last, 1'b1, n);
        while (cyc < last_calc + 1 + TO + 3) tick();
        chk("tmo.count", got_to.size(), 1);
        if (got_to.size() > 0) chk("tmo.time", got_to[0], last_calc + 1 + TO);
        chk("tmo.frame_count", int'(frame_count), exp_fc);
        got_to.delete();

        // Frame start coinciding with the WAIT exit: that whole frame is skipped.
        send_frame(0, V, 1'b1, 1'b0, 1'b0, t_last, n);
        check_frame("pre_skip", t_last, 1'b1, n);
        send_frame(0, V, 1'b0, 1'b1, 1'b0, t_last, n);
        exp_fc++;
        check_frame("skip", t_last, 1'b0, -1);
        chk("skip.frame_count", int'(frame_count), exp_fc);
        chk("skip.no_timeout", got_to.size(), 0);

        // Short frame followed by a full one: only the full frame is counted.
        mode = 1; fill_random();
        thresh_lo = 8'd40; thresh_hi = 8'd220;
        send_frame(0, V / 2, 1'b1, 1'b0, 1'b0, t_last, n);
        send_frame(0, V, 1'b1, 1'b0, 1'b0, t_last, n_full);
        check_frame("short", t_last, n_full != 0, n_full);
        if (n_full != 0) handshake("short", 20);

        // Asynchronous reset while pixels are streaming.
        mode = 2; thresh_lo = 8'd0; thresh_hi = 8'd255;
        send_frame(0, V / 2, 1'b1, 1'b0, 1'b0, t_last, n);
        chk("rst.pre_valid", int'(pixel_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst.pixel_valid", int'(pixel_valid), 0);
        chk("rst.pixel_x", int'(pixel_x), 0);
        chk("rst.pixel_y", int'(pixel_y), 0);
        chk("rst.calculate", int'(calculate), 0);
        chk("rst.mask_count", int'(mask_count), 0);
        chk("rst.frame_count", int'(frame_count), 0);
        chk("rst.timeout_err", int'(timeout_err), 0);
        exp_fc = 0;
        tick();
        exp_px.delete(); got_px.delete(); got_calc.delete(); got_to.delete();
        rst = 1'b0;
        tick();
        send_frame(V / 2, V, 1'b0, 1'b0, 1'b0, t_last, n);
        check_frame("rst.tail", t_last, 1'b0, 0);

        // Full in-threshold frame: whole frame, or the ROI window when enabled.
        send_frame(0, V, 1'b1, 1'b0, 1'b0, t_last, n);
        check_frame("full", t_last, 1'b1, n);
`ifdef MASK_ROI_EN
        chk("full.area", int'(mask_count), (RX1 - RX0 + 1) * (RY1 - RY0 + 1));
`else
        chk("full.area", int'(mask_count), H * V);
`endif
        handshake("full", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
